addsub_seq: RTL and testbench
=============================

Name: addsub_seq

Overview:
- Multi-word add/subtract sequencer built around a single N-bit add/sub slice.
- Performs a WORDS×N-bit add or subtract by iterating the slice once per cycle, least significant word first, and chaining the carry through a register.
- Gives wide-operand arithmetic (default 128-bit) from one 32-bit ripple adder, trading latency for area.
- Sits between the issue logic and the register file: start/done handshake in, full-width result and flags out.

Parameters:
- N, 32, width of one add/sub slice (bits per word).
- WORDS, 4, number of words per operand; total width W = N*WORDS; WORDS >= 1.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a new operation; sampled only when not busy.
- op_sub  input  1  0 = a+b, 1 = a-b; sampled with start.
- a_in  input  W  operand A, word 0 = bits [N-1:0]; sampled with start.
- b_in  input  W  operand B, same layout; sampled with start.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when result and flags become valid.
- result  output  W  sum/difference; held stable from done until the next accepted start.
- cout  output  1  carry out of the top word; for subtract, 1 = no borrow (a >= b unsigned).
- ovf  output  1  signed two's-complement overflow (see Optional Feature).

Behaviour:
- Reset (rst=1 at an edge): state IDLE, busy=0, done=0, result=0, cout=0, ovf=0, word index=0, carry register=0. Reset overrides start and aborts any operation in progress; partial results are discarded.
- States:
  - IDLE: busy=0. start=1 latches a_in, b_in and op_sub into internal registers, sets carry register = op_sub and index = 0, then goes to RUN. start=0 stays in IDLE.
  - RUN: busy=1. Each edge computes, for word i = index:
    - s = a_w[i] + (b_w[i] XOR {N{op}}) + carry, in N+1 bits.
    - result word i <= s[N-1:0]; carry <= s[N]; index <= index+1.
    - On the edge processing word WORDS-1: cout <= s[N], ovf updated, go to DONE.
  - DONE: busy=0, done=1 for exactly this one cycle. start=1 here is accepted exactly as in IDLE (back-to-back operation); otherwise go to IDLE.
- Latency: start sampled at edge k; words processed at edges k+1 .. k+WORDS; done is high in the cycle following edge k+WORDS. Throughput is one operation per WORDS+1 cycles.
- start while busy=1 is ignored and not queued. Input operands may change freely after acceptance.
- result words are written one per cycle during RUN. Values are only guaranteed valid while done=1 and afterwards until the next accepted start; during RUN, result holds a mix of old and new words.
- Width rules: all arithmetic is modulo 2^W. cout is the raw carry of the chained slices. Subtract is the two's complement A + ~B + 1, with the +1 injected as the initial carry.
- WORDS=1 degenerates to a single RUN cycle; this must work.
- Index counter width is clog2(WORDS), minimum 1 bit. The index must never exceed WORDS-1.

Optional Feature:
- Macro ADDSEQ_OVF_EN.
- Defined: on the final word, ovf <= (a_top_msb == b_eff_top_msb) && (s[N-1] != a_top_msb), where b_eff = B XOR {N{op}}. ovf is held with result and cleared by reset.
- Undefined: no overflow logic is synthesized; ovf is tied to 0.
- Port list is identical in both builds.

Test Plan:
- Add with carry across words: A=0x0000_0000_0000_0000_0000_0000_FFFF_FFFF, B=1, op_sub=0, start pulse at cycle 0 -> busy high for cycles 1-4, done high in cycle 5, result=0x...0001_0000_0000, cout=0, ovf=0.
- Subtract borrow through all words: A=0, B=1, op_sub=1 -> result=0xFFFF...FFFF (128 ones), cout=0. Equal operands A=B=0x1234...: -> result=0, cout=1.
- Unsigned wrap and overflow: A=B=0xFFFF...FFFF add -> result=0xFFFF...FFFE, cout=1, ovf=0. A=0x7FFF...FFFF, B=1 add -> result=0x8000...0000, ovf=1 with ADDSEQ_OVF_EN defined, ovf=0 without.
- start asserted with different operands during busy -> ignored; first result unchanged. start held high in the done cycle -> second operation accepted, next done exactly 5 cycles later.
- rst asserted at cycle 2 of RUN -> next cycle busy=0, done=0, result=0, cout=0. No done pulse follows until a new start.
- WORDS=1, N=32 build: 0xFFFFFFFF + 1 -> done 2 cycles after start, result=0, cout=1.

Source files
------------

// File: rtl/addsub_seq.sv
// addsub_seq: multi-word add/subtract sequencer.
// One N-bit add/sub slice is reused once per cycle, least significant word
// first, with the carry chained through a register. A full WORDS*N-bit
// operation takes WORDS cycles in RUN plus one DONE cycle.
//
// Optional build macro: ADDSEQ_OVF_EN
//   defined   -> signed overflow flag computed on the final word
//   undefined -> no overflow logic, ovf tied to 0
//
// Handshake: start is sampled on a rising edge only while busy=0 (IDLE or
// DONE); the edge that samples it also captures op_sub, a_in and b_in, which
// may change freely afterwards. start while busy=1 is dropped, not queued.
// done pulses high for exactly one cycle when result/cout/ovf become valid;
// they then hold until the next accepted start.
module addsub_seq #(
    parameter int N     = 32,
    parameter int WORDS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 op_sub,
    input  logic [N*WORDS-1:0]   a_in,
    input  logic [N*WORDS-1:0]   b_in,
    output logic                 busy,
    output logic                 done,
    output logic [N*WORDS-1:0]   result,
    output logic                 cout,
    output logic                 ovf
);

    localparam int W  = N * WORDS;
    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state;
    state_t         state_next;

    logic [W-1:0]   a_reg;
    logic [W-1:0]   b_reg;
    logic           op_reg;
    logic           carry;
    logic [IW-1:0]  idx;

    logic [N-1:0]   a_w;
    logic [N-1:0]   b_w;
    logic [N-1:0]   b_eff;
    logic [N:0]     s;
    logic           last_word;
    logic           accept;

    // Select the operand words addressed by the current index
    always_comb begin
        a_w = '0;
        b_w = '0;
        for (int w = 0; w < WORDS; w++) begin
            if (idx == IW'(w)) begin
                a_w = a_reg[w*N +: N];
                b_w = b_reg[w*N +: N];
            end
        end
    end

    // The shared slice: subtract is A + ~B with the +1 arriving as the
    // initial carry loaded at accept time
    always_comb begin
        b_eff     = b_w ^ {N{op_reg}};
        s         = {1'b0, a_w} + {1'b0, b_eff} + {{N{1'b0}}, carry};
        last_word = (idx == IW'(WORDS - 1));
        accept    = start && ((state == IDLE) || (state == DONE));
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = start ? RUN : IDLE;
            RUN:     state_next = last_word ? DONE : RUN;
            DONE:    state_next = start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs decoded straight from state
    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end

    // Datapath: capture operands on accept, then one word per RUN cycle;
    // the index wraps to 0 on the last word so it never leaves 0..WORDS-1
    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg  <= '0;
            b_reg  <= '0;
            op_reg <= 1'b0;
            carry  <= 1'b0;
            idx    <= '0;
            result <= '0;
            cout   <= 1'b0;
        end else if (accept) begin
            a_reg  <= a_in;
            b_reg  <= b_in;
            op_reg <= op_sub;
            carry  <= op_sub;
            idx    <= '0;
        end else if (state == RUN) begin
            for (int w = 0; w < WORDS; w++) begin
                if (idx == IW'(w)) begin
                    result[w*N +: N] <= s[N-1:0];
                end
            end
            carry <= s[N];
            if (last_word) begin
                cout <= s[N];
                idx  <= '0;
            end else begin
                idx  <= idx + IW'(1);
            end
        end
    end

`ifdef ADDSEQ_OVF_EN
    // Signed overflow: operands share a sign that the top result bit lacks
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if ((state == RUN) && last_word) begin
            ovf <= (a_w[N-1] == b_eff[N-1]) && (s[N-1] != a_w[N-1]);
        end
    end
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_addsub_seq.sv
// Self-checking bench for addsub_seq: a 128-bit (4 x 32) instance plus a
// single-word (1 x 32) instance sharing clock and reset.
module tb_addsub_seq;

    localparam int N     = 32;
    localparam int WORDS = 4;
    localparam int W     = N * WORDS;
`ifdef ADDSEQ_OVF_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif

    // ---------------- clock / reset / DUTs ----------------
    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          op_sub;
    logic [W-1:0]  a_in;
    logic [W-1:0]  b_in;
    logic          busy;
    logic          done;
    logic [W-1:0]  result;
    logic          cout;
    logic          ovf;

    logic          start1;
    logic          op1;
    logic [N-1:0]  a1;
    logic [N-1:0]  b1;
    logic          busy1;
    logic          done1;
    logic [N-1:0]  result1;
    logic          cout1;
    logic          ovf1;

    always #5 clk = ~clk;

    addsub_seq #(.N(N), .WORDS(WORDS)) dut (
        .clk(clk), .rst(rst), .start(start), .op_sub(op_sub),
        .a_in(a_in), .b_in(b_in), .busy(busy), .done(done),
        .result(result), .cout(cout), .ovf(ovf)
    );

    addsub_seq #(.N(N), .WORDS(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .op_sub(op1),
        .a_in(a1), .b_in(b1), .busy(busy1), .done(done1),
        .result(result1), .cout(cout1), .ovf(ovf1)
    );

    // ---------------- scoreboard ----------------
    // entry = {ovf, cout, result}
    logic [W+1:0] exp_q[$];
    int n_cmp  = 0;
    int n_fail = 0;

    function automatic logic [W+1:0] model(logic [W-1:0] a, logic [W-1:0] b, logic op);
        logic [W:0]   s;
        logic [W-1:0] be;
        logic         v;
        be = op ? ~b : b;
        s  = {1'b0, a} + {1'b0, be} + {{W{1'b0}}, op};
        v  = OVF_ON && (a[W-1] == be[W-1]) && (s[W-1] != a[W-1]);
        return {v, s[W], s[W-1:0]};
    endfunction

    function automatic logic [W-1:0] rand_w();
        logic [W-1:0] r;
        for (int i = 0; i < WORDS; i++) r[i*N +: N] = $urandom;
        return r;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one start pulse; returns in cycle 1 after the accepting edge.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic op, input bit push);
        a_in   = a;
        b_in   = b;
        op_sub = op;
        start  = 1'b1;
        if (push) exp_q.push_back(model(a, b, op));
        tick();
        start  = 1'b0;
        a_in   = rand_w();
        b_in   = rand_w();
        op_sub = $urandom_range(0, 1);
    endtask

    // Wait (bounded) until done is seen; counts edges and busy cycles.
    task automatic wait_done(output int lat, output int busy_cnt);
        lat      = 0;
        busy_cnt = 0;
        while (done !== 1'b1 && lat < 40) begin
            if (busy === 1'b1) busy_cnt++;
            tick();
            lat++;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        n_cmp++;
        if ({busy, done, cout, ovf} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b want 0000", {busy, done, cout, ovf});
        end
        n_cmp++;
        if (result !== '0) begin
            n_fail++;
            $display("FAIL reset_result: got %h want 0", result);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_add_carry();
        logic [W+1:0] e;
        int lat, bc;
        issue(128'h0000_0000_0000_0000_0000_0000_FFFF_FFFF, 128'h1, 1'b0, 1);
        wait_done(lat, bc);
        e = exp_q.pop_front();
        n_cmp++;
        if (lat !== WORDS || bc !== WORDS) begin
            n_fail++;
            $display("FAIL add_carry_latency: got lat=%0d busy=%0d want %0d/%0d", lat, bc, WORDS, WORDS);
        end
        n_cmp++;
        if (result !== 128'h1_0000_0000 || cout !== 1'b0 || ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL add_carry_value: got %h c=%b v=%b want %h c=0 v=0", result, cout, ovf, 128'h1_0000_0000);
        end
        n_cmp++;
        if ({ovf, cout, result} !== e) begin
            n_fail++;
            $display("FAIL add_carry_sb: got %h want %h", {ovf, cout, result}, e);
        end
        tick();
        n_cmp++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL done_one_cycle: got %b want 0", done);
        end
    endtask

    task automatic test_sub_borrow();
        logic [W+1:0] e;
        logic [W-1:0] ones;
        logic [W-1:0] pat;
        int lat, bc;
        ones = '1;
        pat  = 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321;
        issue('0, 128'h1, 1'b1, 1);
        wait_done(lat, bc);
        e = exp_q.pop_front();
        n_cmp++;
        if (result !== ones || cout !== 1'b0 || {ovf, cout, result} !== e) begin
            n_fail++;
            $display("FAIL sub_borrow: got %h c=%b v=%b want %h", result, cout, ovf, e);
        end
        issue(pat, pat, 1'b1, 1);
        wait_done(lat, bc);
        e = exp_q.pop_front();
        n_cmp++;
        if (result !== '0 || cout !== 1'b1 || {ovf, cout, result} !== e) begin
            n_fail++;
            $display("FAIL sub_equal: got %h c=%b v=%b want %h", result, cout, ovf, e);
        end
    endtask

    task automatic test_wrap_ovf();
        logic [W+1:0] e;
        logic [W-1:0] ones;
        logic [W-1:0] maxpos;
        logic [W-1:0] minneg;
        int lat, bc;
        ones   = '1;
        maxpos = {1'b0, {(W-1){1'b1}}};
        minneg = {1'b1, {(W-1){1'b0}}};
        issue(ones, ones, 1'b0, 1);
        wait_done(lat, bc);
        e = exp_q.pop_front();
        n_cmp++;
        if (result !== (ones - 1) || cout !== 1'b1 || ovf !== 1'b0 || {ovf, cout, result} !== e) begin
            n_fail++;
            $display("FAIL wrap_ones: got %h c=%b v=%b want %h", result, cout, ovf, e);
        end
        issue(maxpos, 128'h1, 1'b0, 1);
        wait_done(lat, bc);
        e = exp_q.pop_front();
        n_cmp++;
        if (result !== minneg || cout !== 1'b0 || ovf !== OVF_ON || {ovf, cout, result} !== e) begin
            n_fail++;
            $display("FAIL ovf_maxpos: got %h c=%b v=%b want %h v=%b", result, cout, ovf, minneg, OVF_ON);
        end
        // negative minus positive overflows too
        issue(minneg, 128'h1, 1'b1, 1);
        wait_done(lat, bc);
        e = exp_q.pop_front();
        n_cmp++;
        if ({ovf, cout, result} !== e) begin
            n_fail++;
            $display("FAIL ovf_sub: got %h want %h", {ovf, cout, result}, e);
        end
    endtask

    task automatic test_random();
        logic [W+1:0] e;
        int lat, bc;
        for (int i = 0; i < 8; i++) begin
            issue(rand_w(), rand_w(), $urandom_range(0, 1), 1);
            wait_done(lat, bc);
            e = exp_q.pop_front();
            n_cmp++;
            if (lat !== WORDS || {ovf, cout, result} !== e) begin
                n_fail++;
                $display("FAIL random_%0d: got lat=%0d %h want lat=%0d %h", i, lat, {ovf, cout, result}, WORDS, e);
            end
        end
    endtask

    task automatic test_busy_ignore();
        logic [W+1:0] e;
        int lat, bc, extra;
        issue(128'h0123_4567_89AB_CDEF_0000_1111_2222_3333, 128'h0F0F_0F0F_F0F0_F0F0_1234_4321_5555_AAAA, 1'b0, 1);
        for (int i = 0; i < 3; i++) begin
            a_in   = rand_w();
            b_in   = rand_w();
            op_sub = $urandom_range(0, 1);
            start  = 1'b1;
            tick();
        end
        start = 1'b0;
        wait_done(lat, bc);
        e = exp_q.pop_front();
        n_cmp++;
        if ({ovf, cout, result} !== e) begin
            n_fail++;
            $display("FAIL busy_ignore: got %h want %h", {ovf, cout, result}, e);
        end
        extra = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done === 1'b1 || busy === 1'b1) extra++;
        end
        n_cmp++;
        if (extra !== 0) begin
            n_fail++;
            $display("FAIL busy_not_queued: got %0d active cycles want 0", extra);
        end
    endtask

    task automatic test_back_to_back();
        logic [W+1:0] e;
        logic [W-1:0] a2;
        logic [W-1:0] b2;
        int lat, bc;
        issue(rand_w(), rand_w(), 1'b0, 1);
        wait_done(lat, bc);
        e = exp_q.pop_front();
        n_cmp++;
        if ({ovf, cout, result} !== e) begin
            n_fail++;
            $display("FAIL b2b_first: got %h want %h", {ovf, cout, result}, e);
        end
        // start held in the done cycle is accepted
        a2 = rand_w();
        b2 = rand_w();
        issue(a2, b2, 1'b1, 1);
        wait_done(lat, bc);
        e = exp_q.pop_front();
        n_cmp++;
        if (lat + 1 !== WORDS + 1) begin
            n_fail++;
            $display("FAIL b2b_spacing: got %0d want %0d", lat + 1, WORDS + 1);
        end
        n_cmp++;
        if ({ovf, cout, result} !== e) begin
            n_fail++;
            $display("FAIL b2b_second: got %h want %h", {ovf, cout, result}, e);
        end
        tick();
    endtask

    task automatic test_reset_mid_run();
        int extra;
        issue(128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 128'h5, 1'b0, 0);
        tick();
        rst = 1'b1;
        tick();
        n_cmp++;
        if ({busy, done, cout, ovf} !== 4'b0000 || result !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_run: got b=%b d=%b c=%b v=%b r=%h want all 0", busy, done, cout, ovf, result);
        end
        rst = 1'b0;
        extra = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done === 1'b1 || busy === 1'b1) extra++;
        end
        n_cmp++;
        if (extra !== 0) begin
            n_fail++;
            $display("FAIL reset_no_done: got %0d active cycles want 0", extra);
        end
    endtask

    task automatic test_words1();
        logic [N-1:0] ta[3];
        logic [N-1:0] tb[3];
        logic         top[3];
        logic [N-1:0] tr[3];
        logic         tc[3];
        logic         tv[3];
        int lat;
        ta = '{32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h0000_0005};
        tb = '{32'h0000_0001, 32'h0000_0001, 32'h0000_0007};
        top = '{1'b0, 1'b0, 1'b1};
        tr = '{32'h0000_0000, 32'h8000_0000, 32'hFFFF_FFFE};
        tc = '{1'b1, 1'b0, 1'b0};
        tv = '{1'b0, OVF_ON, 1'b0};
        for (int i = 0; i < 3; i++) begin
            a1 = ta[i];
            b1 = tb[i];
            op1 = top[i];
            start1 = 1'b1;
            tick();
            start1 = 1'b0;
            a1 = $urandom;
            b1 = $urandom;
            lat = 0;
            while (done1 !== 1'b1 && lat < 20) begin
                tick();
                lat++;
            end
            n_cmp++;
            if (lat !== 1 || result1 !== tr[i] || cout1 !== tc[i] || ovf1 !== tv[i]) begin
                n_fail++;
                $display("FAIL words1_%0d: got lat=%0d r=%h c=%b v=%b want lat=1 r=%h c=%b v=%b",
                         i, lat, result1, cout1, ovf1, tr[i], tc[i], tv[i]);
            end
            tick();
        end
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        op_sub = 1'b0;
        a_in   = '0;
        b_in   = '0;
        start1 = 1'b0;
        op1    = 1'b0;
        a1     = '0;
        b1     = '0;
        test_reset();
        test_add_carry();
        test_sub_borrow();
        test_wrap_ovf();
        test_random();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid_run();
        test_words1();
        n_cmp++;
        if (exp_q.size() !== 0) begin
            n_fail++;
            $display("FAIL sb_leftover: got %0d entries want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
